// File: rtl/des_block_packer_pkg.sv
// Shared sizes, fill value and RX state encoding for the DES byte/block adapter.
package des_io_pkg;

    localparam int unsigned BLOCK_BYTES = 8;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BW          = BLOCK_BYTES * BYTE_W;
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES + 1);

    localparam logic [BYTE_W-1:0] TX_FILL = 8'hFF;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_DELIVER = 2'd2
    } rx_state_t;

endpackage

// File: rtl/des_block_packer_tx_byte_serializer.sv
// Returns a loaded 64-bit block to the I2C slave one byte per request, MSB byte first.
module tx_byte_serializer
    import des_io_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic [BW-1:0]     block,
    input  logic              clear,
    input  logic              req,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              tx_empty,
    output logic              tx_underrun
);

    logic [BW-1:0]     sr, sr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BYTE_W-1:0] byte_nxt;
    logic              empty_nxt;
    logic              underrun_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr          <= '0;
            cnt         <= '0;
            tx_byte     <= TX_FILL;
            tx_empty    <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            sr          <= sr_nxt;
            cnt         <= cnt_nxt;
            tx_byte     <= byte_nxt;
            tx_empty    <= empty_nxt;
            tx_underrun <= underrun_nxt;
        end
    end

    // Priority: load, then stop-clear, then byte request.
    always_comb begin
        sr_nxt       = sr;
        cnt_nxt      = cnt;
        byte_nxt     = tx_byte;
        empty_nxt    = tx_empty;
        underrun_nxt = 1'b0;
        if (load) begin
            sr_nxt    = block;
            cnt_nxt   = CNT_W'(BLOCK_BYTES);
            byte_nxt  = block[BW-1 -: BYTE_W];
            empty_nxt = 1'b0;
        end else if (clear) begin
            cnt_nxt   = '0;
            empty_nxt = 1'b1;
            byte_nxt  = TX_FILL;
        end else if (req) begin
            if (cnt > CNT_W'(1)) begin
                sr_nxt   = {sr[BW-BYTE_W-1:0], BYTE_W'(0)};
                cnt_nxt  = cnt - CNT_W'(1);
                byte_nxt = sr[BW-BYTE_W-1 -: BYTE_W];
            end else if (cnt == CNT_W'(1)) begin
                cnt_nxt   = '0;
                empty_nxt = 1'b1;
                byte_nxt  = TX_FILL;
            end else begin
                underrun_nxt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/des_block_packer.sv
// Byte/block adapter between the I2C slave and main_sram: packs RX bytes into
// 64-bit blocks and hands DES results back byte by byte.
module des_block_packer
    import des_io_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_byte_valid,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              i2c_start,
    input  logic              i2c_stop,
    input  logic              output_load_enable,
    input  logic [BW-1:0]     tx_block,
    input  logic              tx_byte_req,
    output logic [BW-1:0]     rx_block,
    output logic              data_ready,
    output logic              frame_error,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              tx_empty,
    output logic              tx_underrun
);

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [BW-1:0]    rx_sr, rx_sr_nxt, rx_block_nxt;
    logic             data_ready_nxt, frame_error_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             boundary;

    assign cnt_inc  = rx_cnt + CNT_W'(1);
    assign boundary = i2c_start | i2c_stop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= RX_IDLE;
            rx_cnt      <= '0;
            rx_sr       <= '0;
            rx_block    <= '0;
            data_ready  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_cnt      <= rx_cnt_nxt;
            rx_sr       <= rx_sr_nxt;
            rx_block    <= rx_block_nxt;
            data_ready  <= data_ready_nxt;
            frame_error <= frame_error_nxt;
        end
    end

    // A completing byte wins over a coincident boundary; any other boundary drops the partial block.
    always_comb begin
        state_nxt       = state;
        rx_cnt_nxt      = rx_cnt;
        rx_sr_nxt       = rx_sr;
        rx_block_nxt    = rx_block;
        data_ready_nxt  = 1'b0;
        frame_error_nxt = 1'b0;
        if (state == RX_DELIVER) begin
            state_nxt = RX_IDLE;
        end
        if (rx_byte_valid) begin
            rx_sr_nxt = {rx_sr[BW-BYTE_W-1:0], rx_byte};
            if (cnt_inc == CNT_W'(BLOCK_BYTES)) begin
                rx_block_nxt   = rx_sr_nxt;
                rx_cnt_nxt     = '0;
                state_nxt      = RX_DELIVER;
                data_ready_nxt = 1'b1;
            end else if (boundary) begin
                rx_cnt_nxt      = '0;
                state_nxt       = RX_IDLE;
                frame_error_nxt = 1'b1;
            end else begin
                rx_cnt_nxt = cnt_inc;
                state_nxt  = RX_COLLECT;
            end
        end else if (boundary && (rx_cnt != '0)) begin
            rx_cnt_nxt      = '0;
            state_nxt       = RX_IDLE;
            frame_error_nxt = 1'b1;
        end
    end

    tx_byte_serializer u_tx (
        .clk         (clk),
        .n_rst       (n_rst),
        .load        (output_load_enable),
        .block       (tx_block),
        .clear       (i2c_stop),
        .req         (tx_byte_req),
        .tx_byte     (tx_byte),
        .tx_empty    (tx_empty),
        .tx_underrun (tx_underrun)
    );

endmodule

// File: tb/tb_des_block_packer.sv
// Bench for des_block_packer: directed vector table, reset corner sequence and
// randomized traffic against a queue-based reference model.
module tb_des_block_packer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        i2c_start;
    logic        i2c_stop;
    logic        output_load_enable;
    logic [63:0] tx_block;
    logic        tx_byte_req;
    logic [63:0] rx_block;
    logic        data_ready;
    logic        frame_error;
    logic [7:0]  tx_byte;
    logic        tx_empty;
    logic        tx_underrun;

    always #5 clk = ~clk;

    des_block_packer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rx_byte_valid      (rx_byte_valid),
        .rx_byte            (rx_byte),
        .i2c_start          (i2c_start),
        .i2c_stop           (i2c_stop),
        .output_load_enable (output_load_enable),
        .tx_block           (tx_block),
        .tx_byte_req        (tx_byte_req),
        .rx_block           (rx_block),
        .data_ready         (data_ready),
        .frame_error        (frame_error),
        .tx_byte            (tx_byte),
        .tx_empty           (tx_empty),
        .tx_underrun        (tx_underrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending RX bytes and unsent TX bytes kept as plain queues.
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_txq[$];
    logic [63:0] m_block;
    bit          m_dr, m_fe, m_un;

    typedef struct {
        bit          v;
        logic [7:0]  b;
        bit          sp;
        bit          ld;
        logic [63:0] blk;
        bit          rq;
        bit          e_dr;
        bit          e_fe;
        logic [63:0] e_blk;
        logic [7:0]  e_tb;
        bit          e_te;
        bit          e_un;
    } tv_t;

    tv_t tv[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_rxq.delete();
        m_txq.delete();
        m_block = '0;
        m_dr = 1'b0;
        m_fe = 1'b0;
        m_un = 1'b0;
    endfunction

    function automatic void model_step(bit v, logic [7:0] b, bit st, bit sp, bit ld,
                                       logic [63:0] blk, bit rq);
        m_dr = 1'b0;
        m_fe = 1'b0;
        m_un = 1'b0;
        if (v) begin
            m_rxq.push_back(b);
            if (m_rxq.size() == 8) begin
                m_block = '0;
                foreach (m_rxq[i]) m_block = (m_block << 8) | 64'(m_rxq[i]);
                m_dr = 1'b1;
                m_rxq.delete();
            end else if (st || sp) begin
                m_rxq.delete();
                m_fe = 1'b1;
            end
        end else if ((st || sp) && m_rxq.size() > 0) begin
            m_rxq.delete();
            m_fe = 1'b1;
        end
        if (ld) begin
            m_txq.delete();
            for (int i = 7; i >= 0; i--) m_txq.push_back(blk[i*8 +: 8]);
        end else if (sp) begin
            m_txq.delete();
        end else if (rq) begin
            if (m_txq.size() == 0) m_un = 1'b1;
            else void'(m_txq.pop_front());
        end
    endfunction

    task automatic check_model();
        logic [7:0] exp_tb;
        exp_tb = (m_txq.size() > 0) ? m_txq[0] : 8'hFF;
        check("model.rx_block", rx_block, m_block);
        check("model.data_ready", 64'(data_ready), 64'(m_dr));
        check("model.frame_error", 64'(frame_error), 64'(m_fe));
        check("model.tx_byte", 64'(tx_byte), 64'(exp_tb));
        check("model.tx_empty", 64'(tx_empty), 64'(m_txq.size() == 0));
        check("model.tx_underrun", 64'(tx_underrun), 64'(m_un));
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit st, input bit sp,
                         input bit ld, input logic [63:0] blk, input bit rq);
        rx_byte_valid      = v;
        rx_byte            = b;
        i2c_start          = st;
        i2c_stop           = sp;
        output_load_enable = ld;
        tx_block           = blk;
        tx_byte_req        = rq;
        @(posedge clk);
        #1;
        model_step(v, b, st, sp, ld, blk, rq);
        check_model();
        rx_byte_valid      = 1'b0;
        i2c_start          = 1'b0;
        i2c_stop           = 1'b0;
        output_load_enable = 1'b0;
        tx_byte_req        = 1'b0;
    endtask

    function automatic void add(bit v, logic [7:0] b, bit sp, bit ld, logic [63:0] blk, bit rq,
                                bit e_dr, bit e_fe, logic [63:0] e_blk, logic [7:0] e_tb,
                                bit e_te, bit e_un);
        tv_t t;
        t.v = v; t.b = b; t.sp = sp; t.ld = ld; t.blk = blk; t.rq = rq;
        t.e_dr = e_dr; t.e_fe = e_fe; t.e_blk = e_blk; t.e_tb = e_tb; t.e_te = e_te; t.e_un = e_un;
        tv.push_back(t);
    endfunction

    initial begin
        logic [63:0] eb;
        logic [63:0] f1;
        logic [63:0] tb1;
        logic [63:0] tb2;
        logic [7:0]  e_tb;

        n_rst = 1'b0;
        rx_byte_valid = 1'b0; rx_byte = '0; i2c_start = 1'b0; i2c_stop = 1'b0;
        output_load_enable = 1'b0; tx_block = '0; tx_byte_req = 1'b0;
        model_reset();
        #12;
        check_model();
        @(negedge clk);
        n_rst = 1'b1;

        // Frame 1: eight bytes spaced four cycles apart.
        eb = '0;
        f1 = 64'h0123456789ABCDEF;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) eb = f1;
            add(1, f1[63-8*i -: 8], 0, 0, '0, 0, i == 7, 0, eb, 8'hFF, 1, 0);
            for (int k = 0; k < 3; k++) add(0, '0, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        end
        // Partial frame dropped by stop, then a clean frame.
        add(1, 8'hAA, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        add(1, 8'hBB, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        add(1, 8'hCC, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        add(0, '0, 1, 0, '0, 0, 0, 1, eb, 8'hFF, 1, 0);
        add(0, '0, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) eb = 64'h1122334455667788;
            add(1, 8'(17 * (i + 1)), 0, 0, '0, 0, i == 7, 0, eb, 8'hFF, 1, 0);
        end
        add(0, '0, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        // Eighth byte coincident with stop still completes.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) eb = 64'hA0A1A2A3A4A5A6A7;
            add(1, 8'(8'hA0 + i), i == 7, 0, '0, 0, i == 7, 0, eb, 8'hFF, i == 7 ? 1'b1 : 1'b1, 0);
        end
        add(0, '0, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        // TX: load, drain eight bytes, then underrun.
        tb1 = 64'hFEDCBA9876543210;
        add(0, '0, 0, 1, tb1, 0, 0, 0, eb, 8'hFE, 0, 0);
        for (int r = 1; r <= 8; r++) begin
            e_tb = (r < 8) ? tb1[63-8*r -: 8] : 8'hFF;
            add(0, '0, 0, 0, '0, 1, 0, 0, eb, e_tb, r == 8, 0);
        end
        add(0, '0, 0, 0, '0, 1, 0, 0, eb, 8'hFF, 1, 1);
        add(0, '0, 0, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        // Load beats a coincident request; stop empties mid-block.
        tb2 = 64'h0102030405060708;
        add(0, '0, 0, 1, tb2, 1, 0, 0, eb, 8'h01, 0, 0);
        add(0, '0, 0, 0, '0, 1, 0, 0, eb, 8'h02, 0, 0);
        add(0, '0, 0, 0, '0, 1, 0, 0, eb, 8'h03, 0, 0);
        add(0, '0, 1, 0, '0, 0, 0, 0, eb, 8'hFF, 1, 0);
        add(0, '0, 0, 0, '0, 1, 0, 0, eb, 8'hFF, 1, 1);

        foreach (tv[i]) begin
            cycle(tv[i].v, tv[i].b, 1'b0, tv[i].sp, tv[i].ld, tv[i].blk, tv[i].rq);
            check($sformatf("tv%0d.data_ready", i), 64'(data_ready), 64'(tv[i].e_dr));
            check($sformatf("tv%0d.frame_error", i), 64'(frame_error), 64'(tv[i].e_fe));
            check($sformatf("tv%0d.rx_block", i), rx_block, tv[i].e_blk);
            check($sformatf("tv%0d.tx_byte", i), 64'(tx_byte), 64'(tv[i].e_tb));
            check($sformatf("tv%0d.tx_empty", i), 64'(tx_empty), 64'(tv[i].e_te));
            check($sformatf("tv%0d.tx_underrun", i), 64'(tx_underrun), 64'(tv[i].e_un));
        end

        // Asynchronous reset mid-cycle after 5 RX bytes and 3 TX bytes.
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h50 + i), 0, 0, 0, '0, 0);
        cycle(0, '0, 0, 0, 1, 64'hCAFEBABE12345678, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 0, '0, 1);
        #3;
        n_rst = 1'b0;
        #1;
        check("rst.rx_block", rx_block, 64'h0);
        check("rst.data_ready", 64'(data_ready), 64'h0);
        check("rst.frame_error", 64'(frame_error), 64'h0);
        check("rst.tx_byte", 64'(tx_byte), 64'hFF);
        check("rst.tx_empty", 64'(tx_empty), 64'h1);
        check("rst.tx_underrun", 64'(tx_underrun), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0, '0, 0);
        check("post_rst.data_ready", 64'(data_ready), 64'h1);
        check("post_rst.rx_block", rx_block, 64'h3031323334353637);
        check("post_rst.frame_error", 64'(frame_error), 64'h0);

        // Randomized traffic against the model, including coincident events.
        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 9) < 5, 8'($urandom), $urandom_range(0, 29) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
                  {$urandom, $urandom}, $urandom_range(0, 9) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
